// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter/rotator built from four power-of-two stages.
// Stage k (amount 2^k) is applied in its own cycle when cnt[k] is set.
// Build option SHIFT_FASTPATH_EN: skip stages whose cnt bit is clear, so
// latency becomes popcount(cnt)+1 and cnt=0 completes with busy never high.
// Without SHIFT_FASTPATH_EN all four stages run, for a fixed five-cycle
// start-to-done latency.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AMT_W = 5;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       stage_q, stage_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] stage_res;
  logic [WIDTH-1:0] stage_val;

  // One stage: apply op by 2^k to the value entering the stage.
  function automatic logic [WIDTH-1:0] stage_xform(
    input logic [1:0]       f_op,
    input logic [1:0]       k,
    input logic [WIDTH-1:0] a
  );
    logic [AMT_W-1:0] amt;
    logic [AMT_W-1:0] inv;
    amt = AMT_W'(1) << k;
    inv = AMT_W'(WIDTH) - amt;
    case (f_op)
      OP_ROL:  stage_xform = (a << amt) | (a >> inv);
      OP_SLL:  stage_xform = a << amt;
      OP_ROR:  stage_xform = (a >> amt) | (a << inv);
      OP_SRA:  stage_xform = WIDTH'($signed(a) >>> amt);
      default: stage_xform = a;
    endcase
  endfunction

`ifdef SHIFT_FASTPATH_EN
  logic [2:0] first_stage;
  logic [2:0] next_stage;

  // Lowest set bit index >= from; 3'd4 when there is none.
  function automatic logic [2:0] lowest_set_from(
    input logic [3:0] bits,
    input logic [2:0] from
  );
    lowest_set_from = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (bits[i] && (3'(i) >= from)) begin
        lowest_set_from = 3'(i);
      end
    end
  endfunction
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    stage_d   = stage_q;
    out_d     = out_q;
    stage_res = stage_xform(op_q, stage_q, acc_q);
    stage_val = cnt_q[stage_q] ? stage_res : acc_q;
`ifdef SHIFT_FASTPATH_EN
    first_stage = lowest_set_from(cnt, 3'd0);
    next_stage  = lowest_set_from(cnt_q, 3'(stage_q) + 3'd1);
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d  = op;
          cnt_d = cnt;
          acc_d = in_data;
`ifdef SHIFT_FASTPATH_EN
          if (first_stage[2]) begin
            // Nothing to shift: the operand is already the result.
            state_d = ST_DONE;
            stage_d = 2'd0;
            out_d   = in_data;
          end else begin
            state_d = ST_SHIFT;
            stage_d = first_stage[1:0];
          end
`else
          state_d = ST_SHIFT;
          stage_d = 2'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        acc_d = stage_val;
`ifdef SHIFT_FASTPATH_EN
        if (next_stage[2]) begin
          state_d = ST_DONE;
          stage_d = 2'd0;
          out_d   = stage_val;
        end else begin
          stage_d = next_stage[1:0];
        end
`else
        if (stage_q == 2'd3) begin
          state_d = ST_DONE;
          stage_d = 2'd0;
          out_d   = stage_val;
        end else begin
          stage_d = stage_q + 2'd1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        stage_d = 2'd0;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      cnt_q   <= 4'd0;
      acc_q   <= '0;
      stage_q <= 2'd0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = out_q;

endmodule
